// File: rtl/mem_req_bridge_if.sv
// Stage-side and bus-side handshake bundle for mem_req_bridge.
// master: stage/bus environment view; slave: bridge view.
interface mem_req_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SW = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic [SW-1:0]     req_wstrb;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_wr;
  logic [DATA_W-1:0] resp_rdata;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [SW-1:0]     bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output req_valid,
    output req_wr,
    output req_size,
    output req_wstrb,
    output req_addr,
    output req_wdata,
    output resp_ready,
    output bus_addr_ok,
    output bus_data_ok,
    output bus_rdata,
    input  req_ready,
    input  resp_valid,
    input  resp_wr,
    input  resp_rdata,
    input  bus_req,
    input  bus_wr,
    input  bus_size,
    input  bus_wstrb,
    input  bus_addr,
    input  bus_wdata
  );

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_size,
    input  req_wstrb,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    input  bus_addr_ok,
    input  bus_data_ok,
    input  bus_rdata,
    output req_ready,
    output resp_valid,
    output resp_wr,
    output resp_rdata,
    output bus_req,
    output bus_wr,
    output bus_size,
    output bus_wstrb,
    output bus_addr,
    output bus_wdata
  );
endinterface

// File: rtl/mem_req_bridge.sv
// Stage valid/ready to SRAM-like addr_ok/data_ok bridge, in-order, flushable.
// Optional perf counters built when MEM_BRIDGE_PERF_EN is defined.
module mem_req_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_req_bridge_if.slave  io,
  output logic             err_unexp,
  output logic [31:0]      perf_req_cnt,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_drop_cnt
);

  localparam int PW = (MAX_OUTST > 1) ?
                      $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW:0] MAXV =
    (CW+1)'(MAX_OUTST);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(MAX_OUTST - 1))
      return '0;
    return p + PW'(1);
  endfunction

  // tracking FIFO: issued, awaiting data_ok
  logic          trk_wr     [MAX_OUTST];
  logic          trk_cancel [MAX_OUTST];
  logic [PW-1:0] trk_wp;
  logic [PW-1:0] trk_rp;
  logic [CW-1:0] trk_cnt;

  // response FIFO: returned, awaiting stage
  logic          rsp_wr   [MAX_OUTST];
  data_t         rsp_data [MAX_OUTST];
  logic [PW-1:0] rsp_wp;
  logic [PW-1:0] rsp_rp;
  logic [CW-1:0] rsp_cnt;

  logic [CW:0] used;
  logic        has_credit;
  logic        accept;
  logic        data_ok_v;
  logic        unexp;
  logic        head_cancel;
  logic        push_rsp;
  logic        drop_rsp;
  logic        pop_rsp;

  assign used = {1'b0, trk_cnt} +
                {1'b0, rsp_cnt};
  assign has_credit = used < MAXV;

  assign io.bus_req = io.req_valid &
                      has_credit &
                      ~flush;
  assign io.bus_wr    = io.req_wr;
  assign io.bus_size  = io.req_size;
  assign io.bus_wstrb = io.req_wstrb;
  assign io.bus_addr  = addr_t'(io.req_addr);
  assign io.bus_wdata = io.req_wdata;

  assign io.req_ready = io.bus_req &
                        io.bus_addr_ok;
  assign accept = io.req_ready;

  assign data_ok_v = io.bus_data_ok &
                     (trk_cnt != '0);
  assign unexp = io.bus_data_ok &
                 (trk_cnt == '0);

  // a flush in the data_ok cycle kills the popped entry too
  assign head_cancel = trk_cancel[trk_rp] | flush;
  assign push_rsp = data_ok_v & ~head_cancel;
  assign drop_rsp = data_ok_v & head_cancel;

  assign io.resp_valid = (rsp_cnt != '0);
  assign pop_rsp = io.resp_valid &
                   io.resp_ready;
  assign io.resp_wr = io.resp_valid &
                      rsp_wr[rsp_rp];
  assign io.resp_rdata = io.resp_valid ?
                         rsp_data[rsp_rp] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_wp  <= '0;
      trk_rp  <= '0;
      trk_cnt <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        trk_wr[i]     <= 1'b0;
        trk_cancel[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < MAX_OUTST; i++)
          trk_cancel[i] <= 1'b1;
      end
      if (accept) begin
        trk_wr[trk_wp]     <= io.req_wr;
        trk_cancel[trk_wp] <= 1'b0;
        trk_wp             <= nxt(trk_wp);
      end
      if (data_ok_v)
        trk_rp <= nxt(trk_rp);
      trk_cnt <= trk_cnt +
                 CW'(accept) -
                 CW'(data_ok_v);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        rsp_wr[i]   <= 1'b0;
        rsp_data[i] <= '0;
      end
    end else if (flush) begin
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (push_rsp) begin
        rsp_wr[rsp_wp]   <= trk_wr[trk_rp];
        rsp_data[rsp_wp] <= trk_wr[trk_rp] ?
                            '0 : io.bus_rdata;
        rsp_wp           <= nxt(rsp_wp);
      end
      if (pop_rsp)
        rsp_rp <= nxt(rsp_rp);
      rsp_cnt <= rsp_cnt +
                 CW'(push_rsp) -
                 CW'(pop_rsp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_unexp <= 1'b0;
    else if (unexp)
      err_unexp <= 1'b1;
  end

`ifdef MEM_BRIDGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (accept)
        perf_req_cnt <= perf_req_cnt + 32'd1;
      if (io.req_valid & ~io.req_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (drop_rsp)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`else
  assign perf_req_cnt   = '0;
  assign perf_stall_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed self-checking bench for mem_req_bridge.
// Perf expectations follow MEM_BRIDGE_PERF_EN.
module tb_mem_req_bridge;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic err_unexp;
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
  int checks = 0;
  int errors = 0;

  mem_req_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_req_bridge #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .io(bif),
    .err_unexp(err_unexp),
    .perf_req_cnt(perf_req_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_drop_cnt(perf_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_wr = 1'b0;
    bif.req_size = 2'd2;
    bif.req_wstrb = 4'hF;
    bif.req_addr = '0;
    bif.req_wdata = '0;
    bif.resp_ready = 1'b0;
    bif.bus_addr_ok = 1'b1;
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp_valid got %b exp 0", bif.resp_valid);
    end
    checks++;
    if (bif.bus_req !== 1'b0 || bif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus_req got %b/%b exp 0/0", bif.bus_req, bif.req_ready);
    end
    checks++;
    if (err_unexp !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b exp 0", err_unexp);
    end
    checks++;
    if ({perf_req_cnt, perf_stall_cnt, perf_drop_cnt} !== 96'd0) begin
      errors++;
      $display("FAIL rst_perf got %0d/%0d/%0d exp 0", perf_req_cnt, perf_stall_cnt, perf_drop_cnt);
    end
  endtask

  task automatic test_single_read();
    bif.req_valid = 1'b1;
    bif.req_wr = 1'b0;
    bif.req_addr = 32'h1000;
    #1;
    checks++;
    if (bif.req_ready !== 1'b1 || bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h1000) begin
      errors++;
      $display("FAIL rd_issue got rdy=%b req=%b addr=%h exp 1 1 1000", bif.req_ready, bif.bus_req, bif.bus_addr);
    end
    tick();
    bif.req_valid = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_resp got %b exp 0", bif.resp_valid);
    end
    tick();
    bif.bus_data_ok = 1'b0;
    checks++;
    if (bif.resp_valid !== 1'b1 || bif.resp_rdata !== 32'hDEADBEEF || bif.resp_wr !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp got v=%b d=%h w=%b exp 1 deadbeef 0", bif.resp_valid, bif.resp_rdata, bif.resp_wr);
    end
`ifdef MEM_BRIDGE_PERF_EN
    checks++;
    if (perf_req_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rd_perf_req got %0d exp 1", perf_req_cnt);
    end
`endif
    bif.resp_ready = 1'b1;
    tick();
    bif.resp_ready = 1'b0;
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_consumed got %b exp 0", bif.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bif.req_valid = 1'b1;
    bif.req_addr = 32'h1100;
    tick();
    tick();
    checks++;
    if (bif.req_ready !== 1'b0 || bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_credit got rdy=%b req=%b exp 0 0", bif.req_ready, bif.bus_req);
    end
    tick();
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'h11;
    tick();
    bif.bus_data_ok = 1'b0;
    bif.resp_ready = 1'b1;
    #1;
    checks++;
    if (bif.req_ready !== 1'b0 || bif.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_buffered got rdy=%b v=%b exp 0 1", bif.req_ready, bif.resp_valid);
    end
    tick();
    bif.resp_ready = 1'b0;
    checks++;
    if (bif.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_third got %b exp 1", bif.req_ready);
    end
    tick();
    bif.req_valid = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'h22;
    tick();
    bif.bus_rdata = 32'h33;
    tick();
    bif.bus_data_ok = 1'b0;
    checks++;
    if (bif.resp_rdata !== 32'h22) begin
      errors++;
      $display("FAIL b2b_order0 got %h exp 22", bif.resp_rdata);
    end
    bif.resp_ready = 1'b1;
    tick();
    checks++;
    if (bif.resp_valid !== 1'b1 || bif.resp_rdata !== 32'h33) begin
      errors++;
      $display("FAIL b2b_order1 got v=%b d=%h exp 1 33", bif.resp_valid, bif.resp_rdata);
    end
    tick();
    bif.resp_ready = 1'b0;
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained got %b exp 0", bif.resp_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_drop;
    bif.req_valid = 1'b1;
    bif.req_addr = 32'h1200;
    tick();
    tick();
    bif.req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'hAA;
    tick();
    bif.bus_rdata = 32'hBB;
    tick();
    bif.bus_data_ok = 1'b0;
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_resp got %b exp 0", bif.resp_valid);
    end
    tick();
    checks++;
    if (bif.resp_valid !== 1'b0 || err_unexp !== 1'b0) begin
      errors++;
      $display("FAIL flush_settle got v=%b err=%b exp 0 0", bif.resp_valid, err_unexp);
    end
`ifdef MEM_BRIDGE_PERF_EN
    exp_drop = 32'd2;
`else
    exp_drop = 32'd0;
`endif
    checks++;
    if (perf_drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL flush_drop got %0d exp %0d", perf_drop_cnt, exp_drop);
    end
  endtask

  task automatic test_flush_collide();
    logic [31:0] exp_drop;
    bif.req_valid = 1'b1;
    bif.req_addr = 32'h1300;
    tick();
    flush = 1'b1;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'hCC;
    #1;
    checks++;
    if (bif.req_ready !== 1'b0 || bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL coll_gate got rdy=%b req=%b exp 0 0", bif.req_ready, bif.bus_req);
    end
    tick();
    flush = 1'b0;
    bif.bus_data_ok = 1'b0;
    bif.req_valid = 1'b0;
    tick();
    checks++;
    if (bif.resp_valid !== 1'b0 || err_unexp !== 1'b0) begin
      errors++;
      $display("FAIL coll_drop got v=%b err=%b exp 0 0", bif.resp_valid, err_unexp);
    end
`ifdef MEM_BRIDGE_PERF_EN
    exp_drop = 32'd3;
`else
    exp_drop = 32'd0;
`endif
    checks++;
    if (perf_drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL coll_perf got %0d exp %0d", perf_drop_cnt, exp_drop);
    end
  endtask

  task automatic test_unexp_write();
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'h99;
    tick();
    bif.bus_data_ok = 1'b0;
    tick();
    checks++;
    if (err_unexp !== 1'b1 || bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL unexp got err=%b v=%b exp 1 0", err_unexp, bif.resp_valid);
    end
    bif.req_valid = 1'b1;
    bif.req_wr = 1'b1;
    bif.req_wstrb = 4'b0011;
    bif.req_addr = 32'h2000;
    bif.req_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (bif.bus_wr !== 1'b1 || bif.bus_wstrb !== 4'b0011 || bif.bus_wdata !== 32'hCAFEF00D || bif.bus_addr !== 32'h2000) begin
      errors++;
      $display("FAIL wr_fields got w=%b s=%b d=%h a=%h exp 1 0011 cafef00d 2000", bif.bus_wr, bif.bus_wstrb, bif.bus_wdata, bif.bus_addr);
    end
    tick();
    bif.req_valid = 1'b0;
    bif.req_wr = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'hFFFFFFFF;
    tick();
    bif.bus_data_ok = 1'b0;
    checks++;
    if (bif.resp_valid !== 1'b1 || bif.resp_wr !== 1'b1 || bif.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp got v=%b w=%b d=%h exp 1 1 0", bif.resp_valid, bif.resp_wr, bif.resp_rdata);
    end
    bif.resp_ready = 1'b1;
    tick();
    bif.resp_ready = 1'b0;
    checks++;
    if (err_unexp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_sticky got %b exp 1", err_unexp);
    end
  endtask

  task automatic test_async_reset();
    bif.req_valid = 1'b1;
    bif.req_addr = 32'h3000;
    tick();
    bif.req_valid = 1'b0;
    bif.bus_data_ok = 1'b1;
    bif.bus_rdata = 32'h55;
    tick();
    bif.bus_data_ok = 1'b0;
    bif.req_valid = 1'b1;
    tick();
    bif.req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bif.resp_valid !== 1'b0 || err_unexp !== 1'b0 || bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got v=%b err=%b req=%b exp 0 0 0", bif.resp_valid, err_unexp, bif.bus_req);
    end
    checks++;
    if ({perf_req_cnt, perf_stall_cnt, perf_drop_cnt} !== 96'd0) begin
      errors++;
      $display("FAIL arst_perf got %0d/%0d/%0d exp 0", perf_req_cnt, perf_stall_cnt, perf_drop_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bif.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_stale got %b exp 0", bif.resp_valid);
    end
    bif.req_valid = 1'b1;
    #1;
    checks++;
    if (bif.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_credit0 got %b exp 1", bif.req_ready);
    end
    tick();
    checks++;
    if (bif.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_credit1 got %b exp 1", bif.req_ready);
    end
    tick();
    checks++;
    if (bif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_full got %b exp 0", bif.req_ready);
    end
    bif.req_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_flush();
    test_flush_collide();
    test_unexp_write();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
